// File: rtl/circle_interp_gen.sv
// Point-by-point comparison circular interpolator: one X or Y unit step per
// step_en tick, walking a circle about the origin from (xs,ys) to (xe,ye).
module circle_interp_gen #(
  parameter int W         = 16,
  parameter int MAX_STEPS = 8 * 2**(W-1),
  parameter int CW_BITS   = $clog2(MAX_STEPS+1)
) (
  input  logic                      pulse_clk,
  input  logic                      sys_rst_l,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      dir_cw,
  input  logic signed [W-1:0]       xs,
  input  logic signed [W-1:0]       ys,
  input  logic signed [W-1:0]       xe,
  input  logic signed [W-1:0]       ye,
  input  logic                      step_en,
  output logic                      busy,
  output logic                      done,
  output logic                      err_flag,
  output logic                      x_step,
  output logic                      y_step,
  output logic                      x_dir,
  output logic                      y_dir,
  output logic signed [W-1:0]       x_pos,
  output logic signed [W-1:0]       y_pos,
  output logic        [CW_BITS-1:0] step_cnt
);
  localparam int FW = 2*W + 2;
  localparam logic signed [W-1:0]  ONE_W   = 1;
  localparam logic signed [FW-1:0] ONE_F   = 1;
  localparam logic [CW_BITS-1:0]   CNT_ONE = 1;
  localparam logic [CW_BITS-1:0]   CNT_MAX = CW_BITS'(MAX_STEPS);

  // Move codes: {is_x, positive}
  localparam logic [1:0] MV_PX = 2'b11;
  localparam logic [1:0] MV_NX = 2'b10;
  localparam logic [1:0] MV_PY = 2'b01;
  localparam logic [1:0] MV_NY = 2'b00;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nxt;

  logic signed [W-1:0]  xe_p0, ye_p0;
  logic                 cw_p0;
  logic signed [FW-1:0] f_p0;

  logic                 xn, yn, xz, yz, fneg;
  logic [1:0]           quad, mv_ge, mv_lt, mv;
  logic signed [W-1:0]  x_nxt, y_nxt;
  logic signed [FW-1:0] sel_ext, f_nxt;
  logic [CW_BITS-1:0]   cnt_nxt;
  logic                 hit_end, out_of_budget, origin_start;

  // Quadrant classification; the boundary axes belong to whichever quadrant
  // the direction of travel is about to enter.
  always_comb begin
    xn   = x_pos[W-1];
    yn   = y_pos[W-1];
    xz   = (x_pos == '0);
    yz   = (y_pos == '0);
    fneg = f_p0[FW-1];
    quad = 2'd0;
    if (cw_p0) begin
      if (xn && !yn)                    quad = 2'd1;
      else if ((xn || xz) && yn)        quad = 2'd2;
      else if (!xn && !xz && (yn || yz)) quad = 2'd3;
    end else begin
      if ((xn || xz) && !yn && !yz)     quad = 2'd1;
      else if (xn && (yn || yz))        quad = 2'd2;
      else if (!xn && yn)               quad = 2'd3;
    end
  end

  always_comb begin
    mv_ge = MV_NY;
    mv_lt = MV_PX;
    case ({cw_p0, quad})
      3'b100:  begin mv_ge = MV_NY; mv_lt = MV_PX; end
      3'b101:  begin mv_ge = MV_PX; mv_lt = MV_PY; end
      3'b110:  begin mv_ge = MV_PY; mv_lt = MV_NX; end
      3'b111:  begin mv_ge = MV_NX; mv_lt = MV_NY; end
      3'b000:  begin mv_ge = MV_NX; mv_lt = MV_PY; end
      3'b001:  begin mv_ge = MV_NY; mv_lt = MV_NX; end
      3'b010:  begin mv_ge = MV_PX; mv_lt = MV_NY; end
      default: begin mv_ge = MV_PY; mv_lt = MV_PX; end
    endcase
    mv = fneg ? mv_lt : mv_ge;
  end

  // F update uses the pre-step coordinate of the moving axis
  always_comb begin
    x_nxt   = x_pos;
    y_nxt   = y_pos;
    if (mv[1]) x_nxt = mv[0] ? x_pos + ONE_W : x_pos - ONE_W;
    else       y_nxt = mv[0] ? y_pos + ONE_W : y_pos - ONE_W;
    sel_ext = mv[1] ? FW'(x_pos) : FW'(y_pos);
    f_nxt   = mv[0] ? f_p0 + (sel_ext <<< 1) + ONE_F
                    : f_p0 - (sel_ext <<< 1) + ONE_F;
    cnt_nxt = step_cnt + CNT_ONE;
    hit_end = (x_nxt == xe_p0) && (y_nxt == ye_p0) && (step_cnt != '0);
    out_of_budget = (cnt_nxt == CNT_MAX);
    origin_start  = (xs == '0) && (ys == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = origin_start ? FIN : RUN;
      RUN: begin
        if (abort)                                     state_nxt = IDLE;
        else if (step_en && (hit_end || out_of_budget)) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) state <= IDLE;
    else            state <= state_nxt;
  end

  assign busy = (state == RUN);
  assign done = (state == FIN);

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      x_pos    <= '0;
      y_pos    <= '0;
      xe_p0    <= '0;
      ye_p0    <= '0;
      cw_p0    <= 1'b0;
      f_p0     <= '0;
      step_cnt <= '0;
      err_flag <= 1'b0;
      x_step   <= 1'b0;
      y_step   <= 1'b0;
      x_dir    <= 1'b0;
      y_dir    <= 1'b0;
    end else begin
      x_step <= 1'b0;
      y_step <= 1'b0;
      if (state == IDLE && start) begin
        x_pos    <= xs;
        y_pos    <= ys;
        xe_p0    <= xe;
        ye_p0    <= ye;
        cw_p0    <= dir_cw;
        f_p0     <= '0;
        step_cnt <= '0;
        err_flag <= origin_start;
      end else if (state == RUN && !abort && step_en) begin
        x_pos    <= x_nxt;
        y_pos    <= y_nxt;
        f_p0     <= f_nxt;
        step_cnt <= cnt_nxt;
        x_step   <= mv[1];
        y_step   <= !mv[1];
        if (mv[1]) x_dir <= mv[0];
        else       y_dir <= mv[0];
        if (!hit_end && out_of_budget) err_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_circle_interp_gen.sv
// Bench for circle_interp_gen: cycle model built from x^2+y^2-R^2 and the
// quadrant/step tables, compared every cycle, plus directed literal checks.
module tb_circle_interp_gen;
  localparam int W    = 16;
  localparam int MAXS = 64;
  localparam int CWB  = $clog2(MAXS+1);

  logic pulse_clk = 1'b0;
  logic sys_rst_l = 1'b0;
  logic start = 1'b0, abort = 1'b0, dir_cw = 1'b0, step_en = 1'b0;
  logic signed [W-1:0] xs = '0, ys = '0, xe = '0, ye = '0;
  logic busy, done, err_flag, x_step, y_step, x_dir, y_dir;
  logic signed [W-1:0] x_pos, y_pos;
  logic [CWB-1:0] step_cnt;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  circle_interp_gen #(.W(W), .MAX_STEPS(MAXS)) dut (
    .pulse_clk(pulse_clk), .sys_rst_l(sys_rst_l), .start(start), .abort(abort),
    .dir_cw(dir_cw), .xs(xs), .ys(ys), .xe(xe), .ye(ye), .step_en(step_en),
    .busy(busy), .done(done), .err_flag(err_flag), .x_step(x_step),
    .y_step(y_step), .x_dir(x_dir), .y_dir(y_dir), .x_pos(x_pos),
    .y_pos(y_pos), .step_cnt(step_cnt));

  always #5 pulse_clk = ~pulse_clk;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Move codes: 0 +X, 1 -X, 2 +Y, 3 -Y; tables indexed by quadrant 0..3 (Q1..Q4)
  int cw_ge[4]  = '{3, 0, 2, 1};
  int cw_lt[4]  = '{0, 2, 1, 3};
  int ccw_ge[4] = '{1, 3, 0, 2};
  int ccw_lt[4] = '{2, 1, 3, 0};

  int m_st = 0;
  int mx = 0, my = 0, mxe = 0, mye = 0, mcnt = 0;
  longint mr2 = 0;
  bit mcw = 0, merr = 0, mxs = 0, mys = 0, mxd = 0, myd = 0;

  function automatic int wrapw(input int v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return int'(t);
  endfunction

  function automatic int quad_of(input bit cw, input int x, input int y);
    if (cw) begin
      if (x >= 0 && y > 0)  return 0;
      if (x < 0 && y >= 0)  return 1;
      if (x <= 0 && y < 0)  return 2;
      if (x > 0 && y <= 0)  return 3;
    end else begin
      if (x > 0 && y >= 0)  return 0;
      if (x <= 0 && y > 0)  return 1;
      if (x < 0 && y <= 0)  return 2;
      if (x >= 0 && y < 0)  return 3;
    end
    return 0;
  endfunction

  task automatic model_step();
    longint f;
    int q, mv;
    f  = longint'(mx)*mx + longint'(my)*my - mr2;
    q  = quad_of(mcw, mx, my);
    if (mcw) mv = (f >= 0) ? cw_ge[q]  : cw_lt[q];
    else     mv = (f >= 0) ? ccw_ge[q] : ccw_lt[q];
    case (mv)
      0: begin mx = wrapw(mx + 1); mxs = 1; mxd = 1; end
      1: begin mx = wrapw(mx - 1); mxs = 1; mxd = 0; end
      2: begin my = wrapw(my + 1); mys = 1; myd = 1; end
      default: begin my = wrapw(my - 1); mys = 1; myd = 0; end
    endcase
    mcnt++;
    if (mx == mxe && my == mye && mcnt > 1) m_st = 2;
    else if (mcnt == MAXS) begin m_st = 2; merr = 1; end
  endtask

  always @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      m_st = 0; mx = 0; my = 0; mcnt = 0; merr = 0;
      mxs = 0; mys = 0; mxd = 0; myd = 0;
    end else begin
      mxs = 0; mys = 0;
      case (m_st)
        0: if (start) begin
          mx = xs; my = ys; mxe = xe; mye = ye; mcw = dir_cw; mcnt = 0;
          mr2 = longint'(xs)*xs + longint'(ys)*ys;
          if (xs == 0 && ys == 0) begin merr = 1; m_st = 2; end
          else begin merr = 0; m_st = 1; end
        end
        1: if (abort) m_st = 0;
           else if (step_en) model_step();
        default: m_st = 0;
      endcase
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge pulse_clk) begin
    if (sys_rst_l && cmp_en) begin
      chk("busy", busy, m_st == 1);
      chk("done", done, m_st == 2);
      chk("err_flag", err_flag, merr);
      chk("x_step", x_step, mxs);
      chk("y_step", y_step, mys);
      chk("x_pos", x_pos, mx);
      chk("y_pos", y_pos, my);
      chk("step_cnt", step_cnt, mcnt);
      if (mxs) chk("x_dir", x_dir, mxd);
      if (mys) chk("y_dir", y_dir, myd);
    end
  end

  // ---------------- directed stimulus ----------------
  int w_nx, w_ny, w_done_cyc, w_done_cnt, w_busy, w_first, w_gap_bad;
  bit w_p04, w_p40;

  task automatic launch(input bit cw, input int x0, input int y0,
                        input int x1, input int y1);
    dir_cw = cw; xs = x0[W-1:0]; ys = y0[W-1:0]; xe = x1[W-1:0]; ye = y1[W-1:0];
    start = 1'b1;
    @(negedge pulse_clk);
    start = 1'b0;
  endtask

  // Cycle k is the k-th cycle after the start edge; step_en for cycle k is
  // driven here and sampled at the end of that cycle.
  task automatic watch(input int period, input int budget, input int abort_at);
    int last;
    bit aborted;
    w_nx = 0; w_ny = 0; w_done_cyc = -1; w_done_cnt = 0; w_busy = 0;
    w_first = -1; w_gap_bad = 0; w_p04 = 0; w_p40 = 0;
    last = -1; aborted = 0;
    for (int k = 1; k <= budget; k++) begin
      if (busy) w_busy++;
      if (x_step || y_step) begin
        if (w_first < 0) w_first = x_step ? (x_dir ? 0 : 1) : (y_dir ? 2 : 3);
        if (last >= 0 && k - last != period) w_gap_bad++;
        last = k;
        if (x_step) w_nx++; else w_ny++;
      end
      if (x_pos == 0 && y_pos == 4) w_p04 = 1;
      if (x_pos == 4 && y_pos == 0) w_p40 = 1;
      if (done) begin
        w_done_cnt++;
        if (w_done_cyc < 0) w_done_cyc = k;
      end
      if (w_done_cyc > 0 && k > w_done_cyc) break;
      abort = 1'b0;
      if (abort_at > 0 && !aborted && (w_nx + w_ny) == abort_at) begin
        abort = 1'b1; aborted = 1;
      end
      step_en = ((k % period) == 0) && (w_done_cyc < 0);
      @(negedge pulse_clk);
    end
    step_en = 1'b0; abort = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge pulse_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_flag, 0);
    chk("rst_pos", {x_pos, y_pos}, 0);
    chk("rst_steps", {x_step, y_step, x_dir, y_dir}, 0);
    chk("rst_cnt", step_cnt, 0);
    sys_rst_l = 1'b1;
    cmp_en = 1'b1;
    @(negedge pulse_clk);

    // CW quarter arc (0,5)->(5,0)
    launch(1, 0, 5, 5, 0);
    watch(1, 30, 0);
    chk("q1_nx", w_nx, 5);
    chk("q1_ny", w_ny, 5);
    chk("q1_first_negy", w_first, 3);
    chk("q1_done_cyc", w_done_cyc, 11);
    chk("q1_done_cnt", w_done_cnt, 1);
    chk("q1_end", {x_pos, y_pos}, {16'sd5, 16'sd0});
    chk("q1_cnt", step_cnt, 10);
    chk("q1_err", err_flag, 0);
    @(negedge pulse_clk);

    // CCW full circle from (3,0)
    launch(0, 3, 0, 3, 0);
    watch(1, 40, 0);
    chk("fc_steps", w_nx + w_ny, 24);
    chk("fc_done_cnt", w_done_cnt, 1);
    chk("fc_end", {x_pos, y_pos}, {16'sd3, 16'sd0});
    chk("fc_cnt", step_cnt, 24);
    @(negedge pulse_clk);

    // CW through three quadrants (-4,0)->(0,-4)
    launch(1, -4, 0, 0, -4);
    watch(1, 40, 0);
    chk("q3_steps", w_nx + w_ny, 24);
    chk("q3_pass_0_4", w_p04, 1);
    chk("q3_pass_4_0", w_p40, 1);
    chk("q3_end", {x_pos, y_pos}, {16'sd0, -16'sd4});
    chk("q3_radius", int'(x_pos)*x_pos + int'(y_pos)*y_pos, 16);
    @(negedge pulse_clk);

    // Paced by step_en every 4th cycle
    launch(1, 0, 5, 5, 0);
    watch(4, 60, 0);
    chk("pace_gap_bad", w_gap_bad, 0);
    chk("pace_busy", w_busy, 40);
    chk("pace_nx", w_nx, 5);
    chk("pace_first", w_first, 3);
    chk("pace_done_cyc", w_done_cyc, 41);
    @(negedge pulse_clk);

    // Start at origin
    launch(1, 0, 0, 3, 3);
    watch(1, 4, 0);
    chk("org_done_cyc", w_done_cyc, 1);
    chk("org_err", err_flag, 1);
    chk("org_steps", w_nx + w_ny, 0);
    @(negedge pulse_clk);

    // Unreachable end point exhausts the budget
    launch(1, 0, 5, 7, 7);
    watch(1, 80, 0);
    chk("bud_done_cyc", w_done_cyc, MAXS + 1);
    chk("bud_cnt", step_cnt, MAXS);
    chk("bud_err", err_flag, 1);
    @(negedge pulse_clk);

    // Abort after 3 steps, together with step_en
    launch(1, 0, 5, 5, 0);
    watch(1, 8, 3);
    chk("ab_steps", w_nx + w_ny, 3);
    chk("ab_busy", w_busy, 4);
    chk("ab_done_cnt", w_done_cnt, 0);
    chk("ab_pos", {x_pos, y_pos}, {16'sd2, 16'sd4});
    chk("ab_err_kept", err_flag, 0);
    @(negedge pulse_clk);

    // Asynchronous reset in the middle of a run
    launch(1, 0, 5, 5, 0);
    watch(1, 5, 0);
    step_en = 1'b1;
    #2 sys_rst_l = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_pos", {x_pos, y_pos}, 0);
    chk("arst_cnt", step_cnt, 0);
    chk("arst_outs", {done, err_flag, x_step, y_step, x_dir, y_dir}, 0);
    step_en = 1'b0;
    @(negedge pulse_clk);
    sys_rst_l = 1'b1;
    repeat (2) @(negedge pulse_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (got running, expected finished)");
    $fatal(1, "timeout");
  end
endmodule
